// File: rtl/mem_pkg.sv
// Shared types for the store write buffer: queued entry layout, buffer state,
// and the data-cache addr_mode encoding.
package mem_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;

    localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
    localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
    localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
    localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
    localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
        logic [2:0]               mode;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_RUN   = 1'b0,
        WB_FLUSH = 1'b1
    } wb_state_t;

    function automatic logic is_word_mode(input logic [2:0] mode);
        return mode == DATA_ADDR_MODE_W;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first word-address search over the queued stores; a full-word match
// forwards its data, a byte/half match reports a conflict.
module wb_fwd_match
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t                  i_entries [DEPTH],
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [PTR_W-1:0]           i_tail,
    input  logic [WB_ADDR_WIDTH-1:2]   i_word_addr,
    output logic                       o_hit,
    output logic                       o_conflict,
    output logic [WB_DATA_WIDTH-1:0]   o_data
);

    logic [PTR_W-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0] w_match;
    logic             w_found;
    logic [2*DEPTH-1:0] w_unused_byte_offsets;

    // Age g=0 is the newest entry (tail-1); age DEPTH-1 wraps round to the head.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age_idx[g] = i_tail - PTR_W'(g + 1);
        assign w_match[g]   = i_valid[w_age_idx[g]] &&
                              (i_entries[w_age_idx[g]].addr[WB_ADDR_WIDTH-1:2] == i_word_addr);
        assign w_unused_byte_offsets[2*g +: 2] = i_entries[g].addr[1:0];
    end

    // NOTE: combinational blocks assign every output a default first so no path
    // leaves a value held over, which would infer a latch.
    always_comb begin
        o_hit      = 1'b0;
        o_conflict = 1'b0;
        o_data     = '0;
        w_found    = 1'b0;
        for (int g = 0; g < DEPTH; g++) begin
            if (!w_found && w_match[g]) begin
                w_found = 1'b1;
                if (is_word_mode(i_entries[w_age_idx[g]].mode)) begin
                    o_hit  = 1'b1;
                    o_data = i_entries[w_age_idx[g]].data;
                end else begin
                    o_conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted write buffer between the write-through data cache and memory: FIFO of
// stores drained one per accepted cycle, with load forwarding and a fence drain.
module store_write_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [2:0]            st_mode,
    input  logic                  ld_check,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_hit,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_conflict,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [2:0]            mem_mode,
    input  logic                  mem_ready,
    input  logic                  flush,
    output logic                  empty,
    output logic [PTR_W:0]        count
);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    wb_state_t        r_state;
    wb_state_t        w_state_next;
    logic [PTR_W:0]   w_count_next;
    logic             w_push;
    logic             w_pop;
    logic             w_fwd_hit;
    logic             w_fwd_conflict;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [1:0]       w_unused_ld_offset;

    assign st_ready = (r_count < (PTR_W+1)'(DEPTH)) && (r_state == WB_RUN);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign mem_we   = !empty;
    assign mem_addr = mem_we ? r_mem[r_head].addr : '0;
    assign mem_wd   = mem_we ? r_mem[r_head].data : '0;
    assign mem_mode = mem_we ? r_mem[r_head].mode : '0;
    assign w_push   = st_valid && st_ready;
    assign w_pop    = mem_we && mem_ready;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // NOTE: entry storage is deliberately not reset; r_valid and r_count gate
    // every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{addr: st_addr, data: st_data, mode: st_mode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= WB_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            WB_RUN:   if (flush && (r_count != '0)) w_state_next = WB_FLUSH;
            WB_FLUSH: if (w_count_next == '0)       w_state_next = WB_RUN;
            default:  w_state_next = WB_RUN;
        endcase
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .i_entries   (r_mem),
        .i_valid     (r_valid),
        .i_tail      (r_tail),
        .i_word_addr (ld_addr[ADDR_WIDTH-1:2]),
        .o_hit       (w_fwd_hit),
        .o_conflict  (w_fwd_conflict),
        .o_data      (w_fwd_data)
    );

    assign w_unused_ld_offset = ld_addr[1:0];
    assign ld_hit      = ld_check && w_fwd_hit;
    assign ld_conflict = ld_check && w_fwd_conflict;
    assign ld_data     = ld_hit ? w_fwd_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based model of the posted write buffer.
module tb_store_write_buffer;
    import mem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, st_valid, st_ready, ld_check, ld_hit, ld_conflict;
    logic        mem_we, mem_ready, flush, empty;
    logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wd;
    logic [2:0]  st_mode, mem_mode, count;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_mode(st_mode),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit),
        .ld_data(ld_data), .ld_conflict(ld_conflict),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_mode(mem_mode), .mem_ready(mem_ready),
        .flush(flush), .empty(empty), .count(count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  mode;
    } ref_store_t;

    ref_store_t  model_q[$];
    bit          model_flushing;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        obs_ready, obs_we, obs_empty, obs_hit, obs_conflict;
    logic [31:0] obs_mem_addr, obs_mem_wd, obs_ld_data;
    logic [2:0]  obs_count;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge, advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] m, input logic lc, input logic [31:0] la,
                        input logic mr, input logic fl, input logic r);
        bit          exp_ready, exp_we, exp_hit, exp_conflict;
        logic [31:0] exp_data;
        int          old_size;
        st_valid = v; st_addr = a; st_data = d; st_mode = m;
        ld_check = lc; ld_addr = la; mem_ready = mr; flush = fl; rst = r;
        @(negedge clk);
        exp_ready    = (model_q.size() < DEPTH) && !model_flushing;
        exp_we       = (model_q.size() != 0);
        exp_hit      = 1'b0;
        exp_conflict = 1'b0;
        exp_data     = 32'h0;
        if (lc) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].addr[31:2] == la[31:2]) begin
                    if (model_q[i].mode == DATA_ADDR_MODE_W) begin
                        exp_hit  = 1'b1;
                        exp_data = model_q[i].data;
                    end else begin
                        exp_conflict = 1'b1;
                    end
                    break;
                end
            end
        end
        obs_ready = st_ready; obs_we = mem_we; obs_empty = empty; obs_count = count;
        obs_hit = ld_hit; obs_conflict = ld_conflict; obs_ld_data = ld_data;
        obs_mem_addr = mem_addr; obs_mem_wd = mem_wd;
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("empty",    32'(empty),    32'(!exp_we));
        check("count",    32'(count),    32'(model_q.size()));
        check("mem_we",   32'(mem_we),   32'(exp_we));
        check("mem_addr", mem_addr, exp_we ? model_q[0].addr : 32'h0);
        check("mem_wd",   mem_wd,   exp_we ? model_q[0].data : 32'h0);
        check("mem_mode", 32'(mem_mode), exp_we ? 32'(model_q[0].mode) : 32'h0);
        check("ld_hit",      32'(ld_hit),      32'(exp_hit));
        check("ld_conflict", 32'(ld_conflict), 32'(exp_conflict));
        if (!lc || exp_hit) check("ld_data", ld_data, exp_data);
        if (r) begin
            model_q.delete();
            model_flushing = 1'b0;
        end else begin
            old_size = model_q.size();
            if (exp_we && mr) void'(model_q.pop_front());
            if (v && exp_ready) model_q.push_back('{addr: a, data: d, mode: m});
            if (!model_flushing) begin
                if (fl && old_size > 0) model_flushing = 1'b1;
            end else if (model_q.size() == 0) begin
                model_flushing = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, mr, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        step(1'b1, a, d, m, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe(input logic [31:0] la);
        step(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, la, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (model_q.size() != 0 && k < 2 * DEPTH + 4) begin
            idle(1'b1);
            k++;
        end
        check("drain_bound", 32'(model_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] modes [5];
        modes[0] = DATA_ADDR_MODE_B;  modes[1] = DATA_ADDR_MODE_H;
        modes[2] = DATA_ADDR_MODE_W;  modes[3] = DATA_ADDR_MODE_BU;
        modes[4] = DATA_ADDR_MODE_HU;
        model_flushing = 1'b0;
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mode = '0;
        ld_check = 1'b0; ld_addr = '0; mem_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and a single store going through
        idle(1'b0);
        check("rst_count", 32'(obs_count), 32'h0);
        check("rst_ready", 32'(obs_ready), 32'h1);
        push(32'h100, 32'hDEADBEEF, DATA_ADDR_MODE_W);
        idle(1'b0);
        check("t1_we",   32'(obs_we), 32'h1);
        check("t1_addr", obs_mem_addr, 32'h100);
        check("t1_wd",   obs_mem_wd, 32'hDEADBEEF);
        idle(1'b1);
        idle(1'b0);
        check("t1_empty", 32'(obs_empty), 32'h1);

        // Fill to DEPTH, refuse the fifth, then drain in order
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), DATA_ADDR_MODE_W);
        push(32'h500, 32'hBAD, DATA_ADDR_MODE_W);
        check("t2_full_ready", 32'(obs_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("t2_order", obs_mem_addr, 32'h400 + 32'(4 * i));
        end
        idle(1'b0);
        check("t2_empty", 32'(obs_empty), 32'h1);

        // Youngest full-word match forwards
        push(32'h200, 32'h11111111, DATA_ADDR_MODE_W);
        push(32'h200, 32'h22222222, DATA_ADDR_MODE_W);
        probe(32'h203);
        check("t3_hit",  32'(obs_hit), 32'h1);
        check("t3_data", obs_ld_data, 32'h22222222);
        check("t3_conf", 32'(obs_conflict), 32'h0);
        drain();

        // Youngest partial match conflicts, then clears once drained
        push(32'h300, 32'hAAAAAAAA, DATA_ADDR_MODE_W);
        push(32'h301, 32'h55, DATA_ADDR_MODE_B);
        probe(32'h300);
        check("t4_conf", 32'(obs_conflict), 32'h1);
        check("t4_hit",  32'(obs_hit), 32'h0);
        drain();
        probe(32'h300);
        check("t4_conf_after", 32'(obs_conflict), 32'h0);
        check("t4_hit_after",  32'(obs_hit), 32'h0);

        // Fence: stores refused until the buffer empties
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 32'(i), DATA_ADDR_MODE_W);
        step(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        push(32'h700, 32'h77, DATA_ADDR_MODE_W);
        check("t5_blocked", 32'(obs_ready), 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h704, 32'h78, DATA_ADDR_MODE_W, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            if (obs_count == 3'd0) break;
        end
        check("t5_count0", 32'(obs_count), 32'h0);
        check("t5_ready",  32'(obs_ready), 32'h1);
        drain();

        // Reset mid-drain discards everything
        for (int i = 0; i < 3; i++) push(32'h800 + 32'(4 * i), 32'(i), DATA_ADDR_MODE_W);
        step(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            check("t6_no_write", 32'(obs_we), 32'h0);
        end
        check("t6_count", 32'(obs_count), 32'h0);
        check("t6_empty", 32'(obs_empty), 32'h1);

        // Random traffic over a small address window to provoke matches
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 1) == 1,
                 32'h100 + 32'($urandom_range(0, 31)),
                 $urandom,
                 modes[$urandom_range(0, 4)],
                 $urandom_range(0, 1) == 1,
                 32'h100 + 32'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
